// File: rtl/maxnet_driver.sv
// Upstream driver for one Maxnet core: gathers four operands, pulses start,
// waits a fixed latency, then returns the result and the index of the matching operand.
module maxnet_driver #(
    parameter int DW        = 32,
    parameter int START_LEN = 2,
    parameter int LAT       = 24
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic [DW-1:0] mx_a0,
    output logic [DW-1:0] mx_a1,
    output logic [DW-1:0] mx_a2,
    output logic [DW-1:0] mx_a3,
    output logic          mx_start,
    input  logic [DW-1:0] mx_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic [1:0]    out_idx,
    output logic          out_match,
    output logic          busy
);

    localparam int CMAX = (START_LEN > LAT) ? START_LEN : LAT;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [1:0] {S_FILL, S_FIRE, S_WAIT, S_HOLD} state_t;

    state_t          state_q, state_d;
    logic [1:0]      idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            start_q, start_d;
    logic [DW-1:0]   data_q, data_d;
    logic [1:0]      oidx_q, oidx_d;
    logic            omatch_q, omatch_d;
    logic [DW-1:0]   slot_q [4];
    logic            wr_en;
    logic [1:0]      hit_idx;
    logic            hit;

    assign wr_en = (state_q == S_FILL) && in_valid && !flush;

    // Scan from the top so the lowest matching slot is the one left standing.
    always_comb begin
        hit     = 1'b0;
        hit_idx = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (slot_q[i] == mx_result) begin
                hit     = 1'b1;
                hit_idx = 2'(i);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        start_d  = start_q;
        data_d   = data_q;
        oidx_d   = oidx_q;
        omatch_d = omatch_q;
        if (flush) begin
            state_d = S_FILL;
            idx_d   = 2'd0;
            cnt_d   = '0;
            start_d = 1'b0;
        end else begin
            case (state_q)
                S_FILL: begin
                    if (in_valid) begin
                        idx_d = idx_q + 2'd1;
                        if (idx_q == 2'd3) begin
                            state_d = S_FIRE;
                            start_d = 1'b1;
                            cnt_d   = '0;
                        end
                    end
                end
                S_FIRE: begin
                    if (cnt_q == CW'(START_LEN - 1)) begin
                        state_d = S_WAIT;
                        start_d = 1'b0;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == CW'(LAT - 1)) begin
                        state_d  = S_HOLD;
                        cnt_d    = '0;
                        data_d   = mx_result;
                        oidx_d   = hit_idx;
                        omatch_d = hit;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (out_ready) state_d = S_FILL;
                end
                default: state_d = S_FILL;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_FILL;
            idx_q    <= 2'd0;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            data_q   <= '0;
            oidx_q   <= 2'd0;
            omatch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            data_q   <= data_d;
            oidx_q   <= oidx_d;
            omatch_q <= omatch_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) slot_q[i] <= '0;
        end else if (wr_en) begin
            slot_q[idx_q] <= in_data;
        end
    end

    assign in_ready  = (state_q == S_FILL);
    assign busy      = (state_q != S_FILL);
    assign out_valid = (state_q == S_HOLD);
    assign out_data  = data_q;
    assign out_idx   = oidx_q;
    assign out_match = omatch_q;
    assign mx_start  = start_q;
    assign mx_a0     = slot_q[0];
    assign mx_a1     = slot_q[1];
    assign mx_a2     = slot_q[2];
    assign mx_a3     = slot_q[3];

endmodule

// File: tb/tb_maxnet_driver.sv
// Self-checking bench for maxnet_driver: directed scenarios plus randomized
// transactions checked against a simple operand-list reference model.
module tb_maxnet_driver;

    localparam int DW        = 32;
    localparam int START_LEN = 2;
    localparam int LAT       = 24;
    localparam int EXP_LAT   = START_LEN + LAT + 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [DW-1:0] in_data = '0;
    logic [DW-1:0] mx_a0, mx_a1, mx_a2, mx_a3;
    logic          mx_start;
    logic [DW-1:0] mx_result = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic [1:0]    out_idx;
    logic          out_match;
    logic          busy;

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] ops [4];

    always #5 clk = ~clk;

    maxnet_driver #(.DW(DW), .START_LEN(START_LEN), .LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .mx_a0(mx_a0), .mx_a1(mx_a1), .mx_a2(mx_a2), .mx_a3(mx_a3),
        .mx_start(mx_start), .mx_result(mx_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_idx(out_idx), .out_match(out_match), .busy(busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w, input int gap);
        repeat (gap) begin
            in_valid = 1'b0;
            in_data  = $urandom;
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = w;
        check("in_ready_fill", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Full transaction: fill, fire, wait, hold, hand off.
    task automatic run_txn(input string name, input logic [DW-1:0] res, input int gap, input int hold);
        int lat, starts, bad;
        logic [1:0] eidx;
        logic ematch;
        ematch = 1'b0;
        eidx   = 2'd0;
        for (int k = 0; k < 4; k++)
            if (!ematch && ops[k] === res) begin
                ematch = 1'b1;
                eidx   = 2'(k);
            end
        mx_result = res;
        for (int k = 0; k < 4; k++) push(ops[k], gap);
        // keep offering junk: it must never be taken while busy
        in_valid = 1'b1;
        in_data  = $urandom;
        check("start_first_cycle", 32'(mx_start), 32'd1);
        lat = 1; starts = 0; bad = 0;
        while (!out_valid && lat < 200) begin
            if (mx_start) starts++;
            if (in_ready || !busy) bad++;
            @(negedge clk);
            lat++;
        end
        check("latency", lat, EXP_LAT);
        check("start_len", starts, START_LEN);
        check("busy_no_ready", bad, 0);
        check("mx_a0", mx_a0, ops[0]);
        check("mx_a1", mx_a1, ops[1]);
        check("mx_a2", mx_a2, ops[2]);
        check("mx_a3", mx_a3, ops[3]);
        out_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_data", out_data, res);
            check("hold_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_data", out_data, res);
        check("out_idx", 32'(out_idx), 32'(eidx));
        check("out_match", 32'(out_match), 32'(ematch));
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("after_valid", 32'(out_valid), 32'd0);
        check("after_ready", 32'(in_ready), 32'd1);
        $display("txn %s: ops %h %h %h %h result %h idx %0d match %0d latency %0d",
                 name, ops[0], ops[1], ops[2], ops[3], out_data, out_idx, out_match, lat);
    endtask

    initial begin
        int sel;
        logic [DW-1:0] r;
        // reset state
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_mx_start", 32'(mx_start), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_match", 32'(out_match), 32'd0);
        check("rst_mx_a0", mx_a0, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // reset in the middle of WAIT
        ops[0] = 32'h11111111; ops[1] = 32'h22222222; ops[2] = 32'h33333333; ops[3] = 32'h44444444;
        for (int k = 0; k < 4; k++) push(ops[k], 0);
        repeat (12) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_mx_start", 32'(mx_start), 32'd0);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_mx_a3", mx_a3, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);

        // directed: spec example, held valid, 10-cycle backpressure
        ops[0] = 32'h4123BE77; ops[1] = 32'h40B00000; ops[2] = 32'h42C88000; ops[3] = 32'h424B0000;
        run_txn("example", 32'h42C88000, 0, 10);

        // duplicates, and a result found in no slot
        ops[0] = 32'h40000000; ops[1] = 32'h41000000; ops[2] = 32'h3F000000; ops[3] = 32'h41000000;
        run_txn("dup_max", 32'h41000000, 0, 1);
        run_txn("no_match", 32'h3F800000, 0, 0);

        // flush after two accepts; the same-cycle word is discarded
        push(32'hDEAD0001, 0);
        push(32'hDEAD0002, 0);
        flush = 1'b1; in_valid = 1'b1; in_data = 32'hDEAD0003;
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        check("flush1_ready", 32'(in_ready), 32'd1);
        check("flush1_start", 32'(mx_start), 32'd0);
        check("flush1_slot0_kept", mx_a0, 32'hDEAD0001);

        // flush during the first FIRE cycle
        ops[0] = 32'hA0; ops[1] = 32'hA1; ops[2] = 32'hA2; ops[3] = 32'hA3;
        for (int k = 0; k < 4; k++) push(ops[k], 0);
        check("fire_start", 32'(mx_start), 32'd1);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush2_start", 32'(mx_start), 32'd0);
        check("flush2_ready", 32'(in_ready), 32'd1);
        sel = 0;
        repeat (40) begin
            if (out_valid || mx_start) sel++;
            @(negedge clk);
        end
        check("flush2_quiet", sel, 0);
        ops[0] = 32'hB0; ops[1] = 32'hB1; ops[2] = 32'hB2; ops[3] = 32'hB3;
        run_txn("refill", 32'hB3, 0, 0);

        // gapped input, one valid in three cycles
        ops[0] = 32'hC0FFEE00; ops[1] = 32'hC0FFEE01; ops[2] = 32'hC0FFEE02; ops[3] = 32'hC0FFEE03;
        run_txn("gapped", 32'hC0FFEE02, 2, 2);

        // randomized transactions
        for (int t = 0; t < 12; t++) begin
            for (int k = 0; k < 4; k++) ops[k] = $urandom;
            if ($urandom_range(0, 3) == 0) ops[$urandom_range(0, 3)] = ops[$urandom_range(0, 3)];
            sel = $urandom_range(0, 4);
            r = (sel == 4) ? DW'($urandom) : ops[sel];
            run_txn($sformatf("rand%0d", t), r, $urandom_range(0, 2), $urandom_range(0, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
